writeback_pipe: RTL and testbench
=================================

WRITEBACK_PIPE -- requirements
Module: writeback_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width; legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_W, default 5, destination register index width.
REQ-003 SHALL have parameter ZERO_REG, default 1, when 1 writes to register index 0 are suppressed.
REQ-004 SHALL have parameter CNT_W, default 16, retire counter width.
REQ-005 SHALL use one clock; reset is synchronous and active-high; ports: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-006 SHALL have ports: flush  in  1  kill in-flight/accepting op; in_valid  in  1  op offered; in_ready  out  1  op accepted when high with in_valid.
REQ-007 SHALL have ports: wb_sel  in  2  source (0 result, 1 mem_data, 2 link, 3 csr_data); write_in  in  1  op writes a register; rd_in  in  ADDR_W  destination index.
REQ-008 SHALL have ports: ld_size  in  2  (0 byte, 1 half, 2 word32, 3 full DATA_W); ld_unsigned  in  1  zero-extend when 1; ld_offset  in  $clog2(DATA_W/8)  byte offset in mem_data.
REQ-009 SHALL have ports: result, link, csr_data  in  DATA_W each; mem_rvalid  in  1  load data valid; mem_data  in  DATA_W  load data.
REQ-010 SHALL have ports: wb_reg  out  DATA_W  write data; wb_addr  out  ADDR_W  write index; write  out  1  register-file write strobe; busy  out  1  state != IDLE; retire_cnt  out  CNT_W  committed writes.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT, DRAIN; in_ready = (state == IDLE).
REQ-012 Accept = in_valid & in_ready; accept with flush high SHALL discard the op (no write, state stays IDLE).
REQ-013 Accepted op with wb_sel != 1 SHALL complete next cycle: wb_reg <= selected source, wb_addr <= rd_in, write <= eff_write.
REQ-014 eff_write = write_in & ~(ZERO_REG & rd == 0).
REQ-015 Accepted op with wb_sel == 1 and mem_rvalid high same cycle SHALL complete next cycle with formatted mem_data.
REQ-016 Accepted op with wb_sel == 1 and mem_rvalid low SHALL latch rd_in, write_in, ld_size, ld_unsigned, ld_offset and enter WAIT.
REQ-017 In WAIT, mem_rvalid high (flush low) SHALL complete using latched fields next cycle and return to IDLE.
REQ-018 In WAIT, flush high with mem_rvalid low SHALL enter DRAIN, no write.
REQ-019 In WAIT, flush and mem_rvalid both high SHALL discard the data, no write, return to IDLE.
REQ-020 In DRAIN, mem_rvalid high SHALL be discarded and return to IDLE; flush in DRAIN has no further effect.
REQ-021 mem_rvalid in IDLE without a wb_sel == 1 accept SHALL be ignored.
REQ-022 Formatting: byte = mem_data[8*off +: 8]; half = mem_data[16*(off>>1) +: 16]; word32 = mem_data[32*(off>>2) +: 32]; full = mem_data; off bits below the access size ignored.
REQ-023 Sign-extend to DATA_W when ld_unsigned = 0, zero-extend when 1; ld_size 2 with DATA_W = 32 equals full.
REQ-024 write SHALL be a single-cycle pulse per completed op; low in all other cycles.
REQ-025 wb_reg and wb_addr SHALL update on every completion (including eff_write = 0) and hold otherwise.
REQ-026 retire_cnt SHALL increment by 1 in the cycle write is high; wraps from all-ones to 0.
REQ-027 Latency: non-load and hit-load 1 cycle accept-to-write; late load 1 cycle after mem_rvalid.

Reset
REQ-028 rst high SHALL force state IDLE, write 0, wb_reg 0, wb_addr 0, retire_cnt 0, discarding any pending op; rst has priority over flush and all inputs.
REQ-029 Reset asserted in WAIT or DRAIN SHALL not leave a pending drain; a later stray mem_rvalid in IDLE is ignored per REQ-021.

Verification
REQ-030 Accept wb_sel 0, result 0x1234_5678, rd 3, write_in 1 -> next cycle write 1, wb_reg 0x1234_5678, wb_addr 3, retire_cnt 1.
REQ-031 wb_sel 1, ld_size 0, ld_unsigned 0, off 2, mem_data 0x0080_0000 with mem_rvalid same cycle -> wb_reg 0xFFFF_FF80; repeat ld_unsigned 1 -> 0x0000_0080.
REQ-032 wb_sel 1, mem_rvalid low 3 cycles then high, data 0xCAFE_F00D, ld_size 3 -> in_ready low, busy high during wait; write 1 cycle after rvalid, wb_reg 0xCAFE_F00D.
REQ-033 Load pending, flush in WAIT, mem_rvalid 2 cycles later, then new op rd 5 -> no write for flushed load, DRAIN consumes rvalid, rd 5 op writes normally.
REQ-034 Accept rd 0 write_in 1 with ZERO_REG 1 -> write 0, wb_addr 0, retire_cnt unchanged.
REQ-035 rst pulsed while in WAIT, then mem_rvalid -> state IDLE, all outputs 0, no write from stray rvalid.

Source files
------------

// File: rtl/writeback_pipe.sv
// writeback_pipe
// Final writeback stage: picks the register write data from one of four
// sources, formats load data (size/offset/sign), waits for late load data,
// and issues a single-cycle register-file write strobe.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   flush             kills the op being accepted or a load waiting for data
//   in_valid/in_ready op handshake (in_ready high only in IDLE)
//   wb_sel            0 result, 1 mem_data (load), 2 link, 3 csr_data
//   write_in, rd_in   op writes a register / destination index
//   ld_size, ld_unsigned, ld_offset   load formatting controls
//   result, link, csr_data           non-load write sources
//   mem_rvalid, mem_data             load data return
//   wb_reg, wb_addr, write           register-file write port
//   busy              high while a load is outstanding (WAIT or DRAIN)
//   retire_cnt        count of write strobes issued (wraps)
//   dbg_state         current FSM state, for observation
//
// Handshake: an op transfers on a rising clk edge where in_valid and in_ready
// are both high; in_ready depends only on registered state, never on
// in_valid, so the upstream stage may hold in_valid until it sees in_ready.
module writeback_pipe #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int CNT_W    = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [1:0]                  wb_sel,
   input  logic                        write_in,
   input  logic [ADDR_W-1:0]           rd_in,
   input  logic [1:0]                  ld_size,
   input  logic                        ld_unsigned,
   input  logic [$clog2(DATA_W/8)-1:0] ld_offset,
   input  logic [DATA_W-1:0]           result,
   input  logic [DATA_W-1:0]           link,
   input  logic [DATA_W-1:0]           csr_data,
   input  logic                        mem_rvalid,
   input  logic [DATA_W-1:0]           mem_data,
   output logic [DATA_W-1:0]           wb_reg,
   output logic [ADDR_W-1:0]           wb_addr,
   output logic                        write,
   output logic                        busy,
   output logic [CNT_W-1:0]            retire_cnt,
   output logic [1:0]                  dbg_state
);

   localparam int OFF_W = $clog2(DATA_W/8);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   wb_reg_q, wb_reg_d;
   logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
   logic                write_q, write_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   // Fields of a load that is waiting for its data
   logic [ADDR_W-1:0]   rd_q, rd_d;
   logic                wr_q, wr_d;
   logic [1:0]          size_q, size_d;
   logic                uns_q, uns_d;
   logic [OFF_W-1:0]    off_q, off_d;

   logic                accept;

   // Offset bits below the access size are masked off before the byte shift.
   function automatic logic [DATA_W-1:0] fmt_load(
      input logic [DATA_W-1:0] d,
      input logic [1:0]        sz,
      input logic              uns,
      input logic [OFF_W-1:0]  off
   );
      logic [DATA_W-1:0] sh;
      logic [DATA_W-1:0] r;
      logic [OFF_W-1:0]  off_m;
      off_m = off;
      case (sz)
         2'd1:    off_m = off & ~OFF_W'(1);
         2'd2:    off_m = off & ~OFF_W'(3);
         default: off_m = off;
      endcase
      sh = d >> {off_m, 3'b000};
      case (sz)
         2'd0:    r = uns ? DATA_W'(sh[7:0])  : DATA_W'($signed(sh[7:0]));
         2'd1:    r = uns ? DATA_W'(sh[15:0]) : DATA_W'($signed(sh[15:0]));
         2'd2:    r = uns ? DATA_W'(sh[31:0]) : DATA_W'($signed(sh[31:0]));
         default: r = d;
      endcase
      return r;
   endfunction

   function automatic logic eff_write(input logic wr, input logic [ADDR_W-1:0] rd);
      return wr & ~((ZERO_REG != 0) && (rd == '0));
   endfunction

   assign accept = in_valid & in_ready;

   always_comb begin
      state_d   = state_q;
      wb_reg_d  = wb_reg_q;
      wb_addr_d = wb_addr_q;
      write_d   = 1'b0;
      rd_d      = rd_q;
      wr_d      = wr_q;
      size_d    = size_q;
      uns_d     = uns_q;
      off_d     = off_q;
      case (state_q)
         S_IDLE: begin
            // flush on the accept cycle swallows the op entirely
            if (accept && !flush) begin
               if (wb_sel != 2'd1) begin
                  case (wb_sel)
                     2'd2:    wb_reg_d = link;
                     2'd3:    wb_reg_d = csr_data;
                     default: wb_reg_d = result;
                  endcase
                  wb_addr_d = rd_in;
                  write_d   = eff_write(write_in, rd_in);
               end else if (mem_rvalid) begin
                  wb_reg_d  = fmt_load(mem_data, ld_size, ld_unsigned, ld_offset);
                  wb_addr_d = rd_in;
                  write_d   = eff_write(write_in, rd_in);
               end else begin
                  rd_d    = rd_in;
                  wr_d    = write_in;
                  size_d  = ld_size;
                  uns_d   = ld_unsigned;
                  off_d   = ld_offset;
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (flush) begin
               // Data arriving with the flush is the killed load's; otherwise
               // its data is still owed and must be absorbed in DRAIN.
               state_d = mem_rvalid ? S_IDLE : S_DRAIN;
            end else if (mem_rvalid) begin
               wb_reg_d  = fmt_load(mem_data, size_q, uns_q, off_q);
               wb_addr_d = rd_q;
               write_d   = eff_write(wr_q, rd_q);
               state_d   = S_IDLE;
            end
         end
         S_DRAIN: begin
            if (mem_rvalid) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      cnt_d = cnt_q + CNT_W'(write_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         wb_reg_q  <= '0;
         wb_addr_q <= '0;
         write_q   <= 1'b0;
         cnt_q     <= '0;
         rd_q      <= '0;
         wr_q      <= 1'b0;
         size_q    <= '0;
         uns_q     <= 1'b0;
         off_q     <= '0;
      end else begin
         state_q   <= state_d;
         wb_reg_q  <= wb_reg_d;
         wb_addr_q <= wb_addr_d;
         write_q   <= write_d;
         cnt_q     <= cnt_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         size_q    <= size_d;
         uns_q     <= uns_d;
         off_q     <= off_d;
      end
   end

   assign in_ready   = (state_q == S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign wb_reg     = wb_reg_q;
   assign wb_addr    = wb_addr_q;
   assign write      = write_q;
   assign retire_cnt = cnt_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_writeback_pipe.sv
// Directed bench for writeback_pipe (default parameters: 32-bit data,
// 5-bit index, register 0 suppressed, 16-bit retire counter).
module tb_writeback_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  wb_sel;
   logic        write_in;
   logic [4:0]  rd_in;
   logic [1:0]  ld_size;
   logic        ld_unsigned;
   logic [1:0]  ld_offset;
   logic [31:0] result;
   logic [31:0] link;
   logic [31:0] csr_data;
   logic        mem_rvalid;
   logic [31:0] mem_data;
   logic [31:0] wb_reg;
   logic [4:0]  wb_addr;
   logic        write;
   logic        busy;
   logic [15:0] retire_cnt;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   writeback_pipe dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .wb_sel(wb_sel), .write_in(write_in), .rd_in(rd_in),
      .ld_size(ld_size), .ld_unsigned(ld_unsigned), .ld_offset(ld_offset),
      .result(result), .link(link), .csr_data(csr_data),
      .mem_rvalid(mem_rvalid), .mem_data(mem_data),
      .wb_reg(wb_reg), .wb_addr(wb_addr), .write(write), .busy(busy),
      .retire_cnt(retire_cnt), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock edge; outputs are sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      flush = 1'b0; in_valid = 1'b0; wb_sel = 2'd0; write_in = 1'b0;
      rd_in = '0; ld_size = 2'd0; ld_unsigned = 1'b0; ld_offset = 2'd0;
      mem_rvalid = 1'b0;
   endtask

   task automatic offer(input logic [1:0] sel, input logic [4:0] rd, input logic wr);
      in_valid = 1'b1; wb_sel = sel; rd_in = rd; write_in = wr;
   endtask

   task automatic load(input logic [4:0] rd, input logic [1:0] sz, input logic uns,
                       input logic [1:0] off, input logic rv, input logic [31:0] d);
      offer(2'd1, rd, 1'b1);
      ld_size = sz; ld_unsigned = uns; ld_offset = off;
      mem_rvalid = rv; mem_data = d;
   endtask

   task automatic expect_wb(input string tag, input logic wr, input logic [31:0] val,
                            input logic [4:0] addr, input logic [15:0] cnt);
      check({tag, "_write"}, 64'(write), 64'(wr));
      check({tag, "_wb_reg"}, 64'(wb_reg), 64'(val));
      check({tag, "_wb_addr"}, 64'(wb_addr), 64'(addr));
      check({tag, "_cnt"}, 64'(retire_cnt), 64'(cnt));
   endtask

   initial begin
      result = 32'h0; link = 32'h0; csr_data = 32'h0; mem_data = 32'h0;
      quiet();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      expect_wb("reset", 1'b0, 32'h0, 5'd0, 16'd0);
      check("reset_in_ready", 64'(in_ready), 64'd1);
      check("reset_busy", 64'(busy), 64'd0);

      // Non-load sources, one-cycle latency
      offer(2'd0, 5'd3, 1'b1); result = 32'h1234_5678;
      tick(); quiet();
      expect_wb("alu", 1'b1, 32'h1234_5678, 5'd3, 16'd1);
      tick();
      check("pulse_low", 64'(write), 64'd0);
      check("hold_reg", 64'(wb_reg), 64'h1234_5678);

      offer(2'd2, 5'd7, 1'b1); link = 32'hAAAA_0001;
      tick(); quiet();
      expect_wb("link", 1'b1, 32'hAAAA_0001, 5'd7, 16'd2);

      offer(2'd3, 5'd31, 1'b1); csr_data = 32'h5555_0003;
      tick(); quiet();
      expect_wb("csr", 1'b1, 32'h5555_0003, 5'd31, 16'd3);

      // Hit loads with formatting
      load(5'd4, 2'd0, 1'b0, 2'd2, 1'b1, 32'h0080_0000);
      tick(); quiet();
      expect_wb("lb", 1'b1, 32'hFFFF_FF80, 5'd4, 16'd4);

      load(5'd4, 2'd0, 1'b1, 2'd2, 1'b1, 32'h0080_0000);
      tick(); quiet();
      expect_wb("lbu", 1'b1, 32'h0000_0080, 5'd4, 16'd5);

      load(5'd8, 2'd1, 1'b0, 2'd3, 1'b1, 32'h8001_1234);
      tick(); quiet();
      expect_wb("lh_hi", 1'b1, 32'hFFFF_8001, 5'd8, 16'd6);

      load(5'd8, 2'd2, 1'b0, 2'd1, 1'b1, 32'h8000_0000);
      tick(); quiet();
      expect_wb("lw", 1'b1, 32'h8000_0000, 5'd8, 16'd7);

      // Late load: inputs changed during the wait must not leak in
      load(5'd9, 2'd3, 1'b0, 2'd0, 1'b0, 32'h0);
      tick(); quiet();
      for (int i = 0; i < 3; i++) begin
         rd_in = 5'd1; ld_size = 2'd0; in_valid = 1'b1; result = 32'h0;
         check("wait_in_ready", 64'(in_ready), 64'd0);
         check("wait_busy", 64'(busy), 64'd1);
         check("wait_write", 64'(write), 64'd0);
         tick();
      end
      in_valid = 1'b0;
      mem_rvalid = 1'b1; mem_data = 32'hCAFE_F00D;
      tick(); quiet();
      expect_wb("late", 1'b1, 32'hCAFE_F00D, 5'd9, 16'd8);
      check("late_busy", 64'(busy), 64'd0);

      // Flush in WAIT, data two cycles later goes to DRAIN
      load(5'd10, 2'd2, 1'b0, 2'd0, 1'b0, 32'h0);
      tick(); quiet();
      flush = 1'b1;
      tick(); quiet();
      check("drain_state", 64'(dbg_state), 64'd2);
      check("drain_write", 64'(write), 64'd0);
      flush = 1'b1;
      tick(); quiet();
      check("drain_hold", 64'(dbg_state), 64'd2);
      mem_rvalid = 1'b1; mem_data = 32'hDEAD_BEEF;
      tick(); quiet();
      check("drain_exit_busy", 64'(busy), 64'd0);
      check("drain_no_write", 64'(write), 64'd0);
      check("drain_cnt", 64'(retire_cnt), 64'd8);
      offer(2'd0, 5'd5, 1'b1); result = 32'h0000_00A5;
      tick(); quiet();
      expect_wb("after_drain", 1'b1, 32'h0000_00A5, 5'd5, 16'd9);

      // Flush and data together in WAIT
      load(5'd11, 2'd2, 1'b0, 2'd0, 1'b0, 32'h0);
      tick(); quiet();
      flush = 1'b1; mem_rvalid = 1'b1; mem_data = 32'h1111_1111;
      tick(); quiet();
      check("fl_rv_busy", 64'(busy), 64'd0);
      expect_wb("fl_rv", 1'b0, 32'h0000_00A5, 5'd5, 16'd9);

      // Flush on accept discards the op
      offer(2'd0, 5'd12, 1'b1); result = 32'h2222_2222; flush = 1'b1;
      tick(); quiet();
      expect_wb("fl_acc", 1'b0, 32'h0000_00A5, 5'd5, 16'd9);
      check("fl_acc_busy", 64'(busy), 64'd0);

      // Register 0 suppression and write_in low still update wb_reg/wb_addr
      offer(2'd0, 5'd0, 1'b1); result = 32'h0000_0077;
      tick(); quiet();
      expect_wb("rd0", 1'b0, 32'h0000_0077, 5'd0, 16'd9);
      offer(2'd0, 5'd6, 1'b0); result = 32'h0000_0066;
      tick(); quiet();
      expect_wb("nowr", 1'b0, 32'h0000_0066, 5'd6, 16'd9);

      // Stray rvalid in IDLE
      mem_rvalid = 1'b1; mem_data = 32'h3333_3333;
      tick(); quiet();
      check("stray_write", 64'(write), 64'd0);
      check("stray_busy", 64'(busy), 64'd0);

      // Reset while waiting, then stray rvalid
      load(5'd13, 2'd2, 1'b0, 2'd0, 1'b0, 32'h0);
      tick(); quiet();
      check("pre_rst_busy", 64'(busy), 64'd1);
      rst = 1'b1; flush = 1'b1;
      tick(); quiet();
      rst = 1'b0;
      expect_wb("rst_wait", 1'b0, 32'h0, 5'd0, 16'd0);
      check("rst_wait_busy", 64'(busy), 64'd0);
      mem_rvalid = 1'b1; mem_data = 32'h4444_4444;
      tick(); quiet();
      expect_wb("rst_stray", 1'b0, 32'h0, 5'd0, 16'd0);
      check("rst_stray_busy", 64'(busy), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
